// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO and its pop-side stream adapter.
package fifo_pkg;
  localparam int SKID_DEPTH      = 2;
  localparam int FIFO_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_t;
endpackage

// File: rtl/fifo_skid2.sv
// Two-entry head/skid buffer; head drives the output, skid absorbs one extra word.
module fifo_skid2 import fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  occ
);
  logic [DATA_WIDTH-1:0] skid, head_nxt, skid_nxt;
  occ_t                  occ_nxt;
  logic                  pop_eff;

  assign pop_eff = pop && (occ != OCC_0);
  assign valid   = (occ != OCC_0);

  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    skid_nxt = skid;
    case ({push, pop_eff})
      2'b10: begin
        if (occ == OCC_0) begin
          head_nxt = push_data;
          occ_nxt  = OCC_1;
        end else begin
          skid_nxt = push_data;
          occ_nxt  = OCC_2;
        end
      end
      2'b01: begin
        head_nxt = skid;
        occ_nxt  = (occ == OCC_2) ? OCC_1 : OCC_0;
      end
      2'b11: begin
        // Occupancy holds; the arrival lands behind whatever is still queued.
        if (occ == OCC_2) begin
          head_nxt = skid;
          skid_nxt = push_data;
        end else begin
          head_nxt = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ  <= OCC_0;
      head <= '0;
      skid <= '0;
    end else begin
      occ  <= occ_nxt;
      head <= head_nxt;
      skid <= skid_nxt;
    end
  end
endmodule

// File: rtl/fifo_pop_stream.sv
// Turns the FIFO pop interface into a registered valid/ready stream with credit-based rd_en.
module fifo_pop_stream import fifo_pkg::*; #(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  idle,
  output logic [CNT_WIDTH-1:0]  delivered_cnt
);
  logic       inflight;
  logic       pop;
  logic [2:0] used;
  occ_t       occ;

  assign pop = out_valid && out_ready;

  // Slots committed after this edge: buffered + in flight, minus the one leaving now.
  assign used       = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rd_en = !fifo_empty && (used < 3'(SKID_DEPTH));

  assign idle = fifo_empty && !inflight && (occ == OCC_0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      delivered_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) delivered_cnt <= delivered_cnt + CNT_WIDTH'(1);
    end
  end

  fifo_skid2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_rdata),
    .pop       (pop),
    .valid     (out_valid),
    .head      (out_data),
    .occ       (occ)
  );
endmodule

// File: tb/tb_fifo_pop_stream.sv
// Bench for fifo_pop_stream: queue-based FIFO environment plus a word-count reference model.
module tb_fifo_pop_stream;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rd_en;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          idle;
  logic [CW-1:0] delivered_cnt;

  always #5 clk = ~clk;

  fifo_pop_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_rdata    (fifo_rdata),
    .fifo_rd_en    (fifo_rd_en),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .idle          (idle),
    .delivered_cnt (delivered_cnt)
  );

  int n_pass = 0, n_chk = 0, cyc = 0;
  logic [7:0] fifo_q[$];   // words resident in the emulated FIFO
  logic [7:0] ref_q[$];    // every word pushed and not yet delivered, in order
  int issued = 0, delivered = 0, last_issue = 0;
  logic s_valid, s_rd_en, s_idle;
  logic [7:0] s_data;
  int s_cnt;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = '0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    ref_q.push_back(w);
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input logic rdy);
    int outst, buffered;
    logic ev, er, mpop, iss;
    out_ready  = rdy;
    fifo_empty = (fifo_q.size() == 0);
    #1;
    outst    = issued - delivered;          // words popped from FIFO, not yet delivered
    buffered = outst - last_issue;          // of those, already captured
    ev   = (buffered > 0);
    mpop = ev && rdy;
    er   = !fifo_empty && ((outst - int'(mpop)) < 2);
    chk("out_valid", int'(out_valid), int'(ev));
    chk("fifo_rd_en", int'(fifo_rd_en), int'(er));
    chk("idle", int'(idle), int'(fifo_empty && outst == 0));
    chk("delivered_cnt", int'(delivered_cnt), delivered % 65536);
    if (ev) chk("out_data", int'(out_data), int'(ref_q[0]));
    if (prev_v && !prev_r) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), int'(prev_d));
    end
    s_valid = out_valid; s_data = out_data; s_rd_en = fifo_rd_en;
    s_idle = idle; s_cnt = int'(delivered_cnt);
    prev_v = out_valid; prev_r = rdy; prev_d = out_data;
    iss = fifo_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (iss && fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
    issued += int'(er);
    if (mpop) begin
      delivered++;
      void'(ref_q.pop_front());
    end
    last_issue = int'(er);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    fifo_q.delete();
    ref_q.delete();
    fifo_empty = 1'b1;
    issued = 0; delivered = 0; last_issue = 0;
    prev_v = 1'b0; prev_r = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_cnt", int'(delivered_cnt), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    @(negedge clk);
  endtask

  initial begin
    int nv, bound;
    logic [7:0] got3[3];

    @(negedge clk);
    do_reset();
    repeat (3) step(1'b1);

    // Single word: pop in T, capture end of T+1, visible in T+2.
    push(8'h5A);
    step(1'b1); chk("single_rd_en_T", int'(s_rd_en), 1); chk("single_valid_T", int'(s_valid), 0);
    step(1'b1); chk("single_valid_T1", int'(s_valid), 0);
    step(1'b1); chk("single_valid_T2", int'(s_valid), 1); chk("single_data", int'(s_data), 'h5A);
    step(1'b1); chk("single_cnt", s_cnt, 1); chk("single_idle", int'(s_idle), 1);

    // Streaming 0x01..0x10 at full rate.
    do_reset();
    for (int i = 1; i <= 16; i++) push(8'(i));
    step(1'b1); step(1'b1);
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1);
      if (s_valid) nv++;
    end
    chk("stream_valid_cycles", nv, 16);
    step(1'b1);
    chk("stream_cnt", s_cnt, 16);

    // Backpressure: third word must stay in the FIFO.
    do_reset();
    push(8'h20); push(8'h21); push(8'h22);
    repeat (4) step(1'b0);
    chk("bp_rd_en", int'(s_rd_en), 0);
    chk("bp_fifo_left", fifo_q.size(), 1);
    chk("bp_head", int'(s_data), 'h20);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      got3[i] = s_valid ? s_data : 8'h00;
    end
    chk("bp_word0", int'(got3[0]), 'h20);
    chk("bp_word1", int'(got3[1]), 'h21);
    chk("bp_word2", int'(got3[2]), 'h22);

    // Alternating ready over 0xA0..0xA7.
    do_reset();
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    bound = 0;
    while (delivered < 8 && bound < 60) begin
      step(bound % 2 == 0);
      bound++;
    end
    chk("alt_delivered", delivered, 8);
    step(1'b0);
    chk("alt_cnt", s_cnt, 8);

    // Reset with a word buffered and one in flight.
    do_reset();
    push(8'h31); push(8'h32); push(8'h33);
    step(1'b0); step(1'b0);
    do_reset();
    nv = 0;
    repeat (6) begin
      step(1'b1);
      if (s_valid) nv++;
    end
    chk("post_reset_stale", nv, 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) push(8'($urandom_range(0, 255)));
      step($urandom_range(0, 1) == 1);
    end
    bound = 0;
    while (ref_q.size() > 0 && bound < 50) begin
      step(1'b1);
      bound++;
    end
    chk("rand_drained", ref_q.size(), 0);
    step(1'b1);
    chk("rand_idle", int'(s_idle), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
